// File: rtl/sprite_arb_pkg.sv
// sprite_arb_pkg
// Shared constants and types for the sprite ROM arbiter.
//   *_DEF      default parameter values for the arbiter
//   MAX_REQ    upper bound on requesters; tag ids are sized to it so one
//              tag type serves any legal NUM_REQ
//   OOR_INDEX  ROM index driven for out-of-range requests
//   req_idx_t  requester index, tag_t in-flight tag (one-hot id + err)
package sprite_arb_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int ADDR_W_DEF    = 11;
  localparam int DATA_W_DEF    = 4;
  localparam int ROM_DEPTH_DEF = 1296;
  localparam int ROM_LAT_DEF   = 2;

  localparam int MAX_REQ   = 8;
  localparam int IDX_W     = 3;
  localparam int OOR_INDEX = 0;

  typedef logic [MAX_REQ-1:0] req_id_t;
  typedef logic [IDX_W-1:0]   req_idx_t;

  typedef struct packed {
    req_id_t id;
    logic    err;
  } tag_t;

  // True when a tag belongs to a real, in-range read whose ROM data is kept.
  function automatic logic tag_hit(input tag_t t);
    return (|t.id) & ~t.err;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if
// Requester / ROM / response bundle of the sprite ROM arbiter.
//   req_valid, req_addr : requester side requests (req i at [i*ADDR_W +: ADDR_W])
//   req_ready           : one-hot grant back to requesters
//   rom_address, rom_q  : shared ROM read port
//   rsp_valid, rsp_data, rsp_err : registered response
//   busy                : reads in flight
// Modports: master = requesters + ROM (environment), slave = arbiter.
interface sprite_rom_arbiter_if
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_q;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      busy;

  modport master (
    output req_valid, req_addr, rom_q,
    input  req_ready, rom_address, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_addr, rom_q,
    output req_ready, rom_address, rsp_valid, rsp_data, rsp_err, busy
  );

endinterface

// File: rtl/sprite_arb_tag_pipe.sv
// sprite_arb_tag_pipe
// DEPTH-stage shift register of in-flight tags with synchronous clear.
//   vga_clk   : clock
//   clear     : synchronous clear of every stage
//   shift_in  : tag entering this cycle (all-zero when no grant)
//   tail_id   : one-hot id of the oldest stage (drives rsp_valid)
//   tail_err  : error flag of the oldest stage (drives rsp_err)
//   load_data : stage before the tail holds an in-range read, so ROM data
//               sampled this cycle belongs to the next response
//   busy_next : something will be in flight after the coming edge
module sprite_arb_tag_pipe
  import sprite_arb_pkg::*;
#(
  parameter int DEPTH  = ROM_LAT_DEF + 1,
  parameter int NUM_ID = NUM_REQ_DEF
) (
  input  logic              vga_clk,
  input  logic              clear,
  input  tag_t              shift_in,
  output logic [NUM_ID-1:0] tail_id,
  output logic              tail_err,
  output logic              load_data,
  output logic              busy_next
);

  tag_t stages_r [DEPTH];

  // Advance every tag one stage per cycle; clear drops all in-flight reads.
  always_ff @(posedge vga_clk) begin
    if (clear) begin
      for (int k = 0; k < DEPTH; k++) begin
        stages_r[k] <= '0;
      end
    end else begin
      stages_r[0] <= shift_in;
      for (int k = 1; k < DEPTH; k++) begin
        stages_r[k] <= stages_r[k-1];
      end
    end
  end

  assign tail_id   = stages_r[DEPTH-1].id[NUM_ID-1:0];
  assign tail_err  = stages_r[DEPTH-1].err;
  assign load_data = tag_hit(stages_r[DEPTH-2]);

  // The tail leaves at the coming edge, so only the new tag and the
  // younger stages keep the arbiter busy afterwards.
  always_comb begin
    busy_next = |shift_in.id;
    for (int k = 0; k < DEPTH-1; k++) begin
      busy_next = busy_next | (|stages_r[k].id);
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
// Round-robin arbiter sharing one sprite ROM read port among NUM_REQ
// requesters, with in-order tagged responses ROM_LAT+1 cycles after grant.
//   vga_clk : pixel clock
//   reset   : synchronous active-high reset
//   bus     : sprite_rom_arbiter_if.slave (requests, ROM port, responses)
// Build option: define SPRITE_ARB_PRIORITY_EN to give requester 0 (display
// scan-out) absolute priority; requesters 1..NUM_REQ-1 then rotate among
// themselves. Undefined: plain round-robin over all requesters.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ROM_DEPTH = ROM_DEPTH_DEF,
  parameter int ROM_LAT   = ROM_LAT_DEF
) (
  input logic                 vga_clk,
  input logic                 reset,
  sprite_rom_arbiter_if.slave bus
);

`ifdef SPRITE_ARB_PRIORITY_EN
  localparam req_idx_t PTR_RST = 3'd1;
`else
  localparam req_idx_t PTR_RST = 3'd0;
`endif

  req_id_t           valid8_s;
  req_id_t           grant8_s;
  req_idx_t          idx_s;
  req_idx_t          win_idx_s;
  req_idx_t          ptr_r;
  req_idx_t          ptr_next_s;
  logic              found_s;
  logic              hit_s;
  logic              handshake_s;
  logic              oor_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [ADDR_W-1:0] rom_address_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic              busy_r;
  tag_t              tag_in_s;
  logic              load_data_s;
  logic              busy_next_s;

  assign valid8_s = req_id_t'(bus.req_valid);

  // Winner search: first valid requester at or after ptr, wrapping.
  always_comb begin
    found_s   = 1'b0;
    hit_s     = 1'b0;
    idx_s     = 3'd0;
    win_idx_s = 3'd0;
`ifdef SPRITE_ARB_PRIORITY_EN
    found_s   = valid8_s[0];
    for (int k = 0; k < NUM_REQ-1; k++) begin
      idx_s     = req_idx_t'(1 + ((int'(ptr_r) - 1 + k) % (NUM_REQ - 1)));
      hit_s     = !found_s && valid8_s[idx_s];
      win_idx_s = hit_s ? idx_s : win_idx_s;
      found_s   = found_s || hit_s;
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s     = req_idx_t'((int'(ptr_r) + k) % NUM_REQ);
      hit_s     = !found_s && valid8_s[idx_s];
      win_idx_s = hit_s ? idx_s : win_idx_s;
      found_s   = found_s || hit_s;
    end
`endif
    // Grants are suppressed while reset is held.
    grant8_s = (found_s && !reset) ? (req_id_t'(1'b1) << win_idx_s) : '0;
  end

  assign handshake_s   = |grant8_s;
  assign bus.req_ready = grant8_s[NUM_REQ-1:0];
  assign win_addr_s    = bus.req_addr[int'(win_idx_s)*ADDR_W +: ADDR_W];
  assign oor_s         = 32'(win_addr_s) >= 32'(ROM_DEPTH);
  assign tag_in_s      = '{id: grant8_s, err: oor_s && handshake_s};

  // Pointer advance: one past the winner, wrapping to the first rotating slot.
  always_comb begin
`ifdef SPRITE_ARB_PRIORITY_EN
    if (win_idx_s == 3'd0) begin
      ptr_next_s = ptr_r;
    end else if (int'(win_idx_s) == NUM_REQ - 1) begin
      ptr_next_s = 3'd1;
    end else begin
      ptr_next_s = win_idx_s + 3'd1;
    end
`else
    if (int'(win_idx_s) == NUM_REQ - 1) begin
      ptr_next_s = 3'd0;
    end else begin
      ptr_next_s = win_idx_s + 3'd1;
    end
`endif
  end

  // Pointer and ROM address update on each handshake.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      ptr_r         <= PTR_RST;
      rom_address_r <= '0;
    end else if (handshake_s) begin
      ptr_r         <= ptr_next_s;
      rom_address_r <= oor_s ? ADDR_W'(OOR_INDEX) : win_addr_s;
    end
  end

  sprite_arb_tag_pipe #(
    .DEPTH  (ROM_LAT + 1),
    .NUM_ID (NUM_REQ)
  ) u_tag_pipe (
    .vga_clk   (vga_clk),
    .clear     (reset),
    .shift_in  (tag_in_s),
    .tail_id   (bus.rsp_valid),
    .tail_err  (bus.rsp_err),
    .load_data (load_data_s),
    .busy_next (busy_next_s)
  );

  // Response data and busy flag; error reads return zero, not ROM contents.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rsp_data_r <= '0;
      busy_r     <= 1'b0;
    end else begin
      rsp_data_r <= load_data_s ? bus.rom_q : '0;
      busy_r     <= busy_next_s;
    end
  end

  assign bus.rom_address = rom_address_r;
  assign bus.rsp_data    = rsp_data_r;
  assign bus.busy        = busy_r;

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
- REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one sprite ROM read port (legal range 2..8).
- REQ-002 Parameter ADDR_W, default 11: ROM address width.
- REQ-003 Parameter DATA_W, default 4: ROM word width (palette index).
- REQ-004 Parameter ROM_DEPTH, default 1296: number of valid ROM words (36x36 sprite).
- REQ-005 Parameter ROM_LAT, default 2: cycles from rom_address register update to valid rom_q (legal range 1..4).
- REQ-006 Clocking: one clock; reset is synchronous and active-high.
- REQ-007 vga_clk  in  1  pixel clock; all state updates on posedge.
- REQ-008 reset  in  1  synchronous active-high reset.
- REQ-009 req_valid  in  NUM_REQ  per-requester read request.
- REQ-010 req_addr  in  NUM_REQ*ADDR_W  per-requester address, requester i at bits [i*ADDR_W +: ADDR_W].
- REQ-011 req_ready  out  NUM_REQ  one-hot grant, combinational from req_valid and arbiter state.
- REQ-012 rom_address  out  ADDR_W  registered address to ROM.
- REQ-013 rom_q  in  DATA_W  ROM read data.
- REQ-014 rsp_valid  out  NUM_REQ  one-hot response strobe, registered.
- REQ-015 rsp_data  out  DATA_W  response data, registered.
- REQ-016 rsp_err  out  1  response was for an out-of-range address, registered.
- REQ-017 busy  out  1  high while any read is in flight.

Function
- REQ-018 A handshake on requester i occurs in a cycle where req_valid[i] and req_ready[i] are both 1. At most one handshake shall occur per cycle.
- REQ-019 req_ready shall be all-zero when req_valid is all-zero, and shall never assert for a requester whose req_valid is 0.
- REQ-020 Round-robin: a pointer ptr names the highest-priority requester. The winner is the first valid requester at or after ptr, modulo NUM_REQ.
- REQ-021 After a handshake by requester i, ptr shall become (i+1) mod NUM_REQ, wrapping NUM_REQ-1 to 0. Without a handshake, ptr shall hold.
- REQ-022 On a handshake, rom_address shall load the winner's address on the same edge. Addresses >= ROM_DEPTH shall drive rom_address to 0 and tag the transaction as an error.
- REQ-023 Exactly 1+ROM_LAT cycles after the handshake cycle:
  - rsp_valid shall pulse for one cycle on the winner's bit;
  - rsp_data shall equal rom_q sampled that cycle (0 when rsp_err=1);
  - rsp_err shall carry the error tag.
- REQ-024 Throughput: one handshake per cycle back-to-back. Responses return in grant order, and each response shall pair with the tag of its own grant.
- REQ-025 rsp_data, rsp_err and the rsp_valid bits other than the responding bit shall be 0 in cycles without a response.
- REQ-026 busy shall be 1 from the cycle after any handshake until the cycle its last in-flight response is issued, inclusive.
- REQ-027 req_valid deasserting without a handshake is legal; the request is dropped and ptr is unchanged.

Reset
- REQ-028 While reset=1, on each posedge:
  - ptr=0 and rom_address=0;
  - rsp_valid=0, rsp_data=0, rsp_err=0, busy=0;
  - all in-flight tags are cleared.
- REQ-029 During reset, req_ready shall be all-zero.
- REQ-030 Reset asserted mid-operation shall discard in-flight reads: no rsp_valid for them, ever. The first grant after reset deasserts follows ptr=0.

Configuration
- REQ-031 Macro SPRITE_ARB_PRIORITY_EN:
  - Defined: requester 0 (display scan-out) shall win whenever req_valid[0]=1, regardless of ptr. Requesters 1..NUM_REQ-1 round-robin among themselves. ptr never selects 0 and wraps NUM_REQ-1 to 1.
  - Undefined: pure round-robin per REQ-020/021.

Structure
- REQ-032 Package sprite_arb_pkg shall hold the default constants for NUM_REQ, ADDR_W, DATA_W, ROM_DEPTH and ROM_LAT. It shall also hold the typedef req_id_t, the tag struct (one-hot id plus err bit) and the out-of-range index constant.
- REQ-033 Sub-module sprite_arb_tag_pipe: a ROM_LAT+1 deep shift register of tags with a synchronous clear. The arbiter shall instantiate it once.

Verification
- REQ-034 Single request: req_valid=0001, addr0=5, rom_q=7 at the response cycle:
  - req_ready=0001 in the same cycle;
  - rom_address=5 on the next edge;
  - rsp_valid=0001 with rsp_data=7 after 3 cycles (ROM_LAT=2).
- REQ-035 All four valid and held for 8 cycles: grant order 0,1,2,3,0,1,2,3; 8 responses back-to-back, each with the matching rsp_valid bit.
- REQ-036 Out-of-range: addr2=1296 -> rom_address=0, rsp_valid=0100, rsp_err=1, rsp_data=0.
- REQ-037 Reset mid-flight: two handshakes, then reset for 1 cycle the next cycle -> no rsp_valid afterwards, busy=0; the next all-valid grant goes to requester 0.
- REQ-038 SPRITE_ARB_PRIORITY_EN defined, req_valid held at 1111 for 6 cycles -> requester 0 granted on all 6 cycles; with 1110 held: order 1,2,3,1,2,3.
- REQ-039 Pointer hold: grant requester 2, then 3 idle cycles, then all valid -> requester 3 wins.
